// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial pattern detector with
// compare mask, overlap mode, valid qualifier and saturating counter.
module seq_detector_param #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int FILL_W  = $clog2(PAT_LEN+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic [PAT_LEN-1:0] cfg_mask,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               input_bit,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               sat,
  output logic [FILL_W-1:0]  fill
);

  localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] ARMED = FILL_W'(PAT_LEN-1);

  logic [PAT_LEN-1:0] history;
  logic [PAT_LEN-1:0] pattern;
  logic [PAT_LEN-1:0] mask;
  logic               overlap;

  logic [PAT_LEN-1:0] window;
  logic               accept;
  logic               hit;

  logic [PAT_LEN-1:0] history_nxt;
  logic [FILL_W-1:0]  fill_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               sat_nxt;

  assign accept = in_valid & ~cfg_load;
  assign window = {history[PAT_LEN-2:0], input_bit};

  // fill gate keeps stale zeros in history from completing a match
  assign hit = accept
            && (((window ^ pattern) & mask) == '0)
            && (fill >= ARMED);

  always_comb begin
    history_nxt = history;
    fill_nxt    = fill;
    unique case (1'b1)
      cfg_load: begin
        history_nxt = '0;
        fill_nxt    = '0;
      end
      accept: begin
        if (hit && !overlap) begin
          history_nxt = '0;
          fill_nxt    = '0;
        end else begin
          history_nxt = window;
          fill_nxt    = (fill == FULL) ? FULL : fill + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // clear has priority over a same-cycle hit
  always_comb begin
    cnt_nxt = match_count;
    sat_nxt = sat;
    if (clr_count) begin
      cnt_nxt = '0;
      sat_nxt = 1'b0;
    end else begin
      if (hit && (match_count != '1))
        cnt_nxt = match_count + 1'b1;
      sat_nxt = sat | (cnt_nxt == '1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history     <= '0;
      pattern     <= '0;
      mask        <= '1;
      overlap     <= 1'b1;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      sat         <= 1'b0;
    end else begin
      if (cfg_load) begin
        pattern <= cfg_pattern;
        mask    <= cfg_mask;
        overlap <= cfg_overlap;
      end
      history     <= history_nxt;
      fill        <= fill_nxt;
      match       <= hit;
      match_count <= cnt_nxt;
      sat         <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table vectors, directed corner sequences
// and random stimulus against a queue-based reference model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic [3:0] cfg_mask;
  logic       cfg_overlap;
  logic       in_valid;
  logic       input_bit;
  logic       clr_count;

  logic       a_match, b_match;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  logic       a_sat, b_sat;
  logic [2:0] a_fill, b_fill;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(4), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .input_bit(input_bit), .clr_count(clr_count),
    .match(a_match), .match_count(a_cnt),
    .sat(a_sat), .fill(a_fill)
  );

  seq_detector_param #(.PAT_LEN(4), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .input_bit(input_bit), .clr_count(clr_count),
    .match(b_match), .match_count(b_cnt),
    .sat(b_sat), .fill(b_fill)
  );

  // reference model: bits accepted since the last restart
  bit       q[$];
  bit [3:0] m_pat, m_mask;
  bit       m_ov, m_match;
  int       m_cnt_a, m_cnt_b;
  bit       m_sat_a, m_sat_b;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_pat = '0; m_mask = '1; m_ov = 1'b1; m_match = 1'b0;
    m_cnt_a = 0; m_cnt_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
  endfunction

  function automatic void model_edge(bit ld, bit [3:0] p, bit [3:0] m,
                                     bit ov, bit v, bit b, bit clr);
    bit hit = 1'b0;
    bit wb;
    if (ld) begin
      m_pat = p; m_mask = m; m_ov = ov;
      q.delete();
    end else if (v) begin
      if (q.size() >= 3) begin
        hit = 1'b1;
        for (int k = 0; k < 4; k++) begin
          wb = (k == 0) ? b : q[q.size()-k];
          if (m_mask[k] && (wb != m_pat[k])) hit = 1'b0;
        end
      end
      q.push_back(b);
      if (hit && !m_ov) q.delete();
      while (q.size() > 4) void'(q.pop_front());
    end
    m_match = hit;
    if (clr) begin
      m_cnt_a = 0; m_cnt_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
    end else if (hit) begin
      m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
      m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
      if (m_cnt_a == 255) m_sat_a = 1'b1;
      if (m_cnt_b == 3) m_sat_b = 1'b1;
    end
  endfunction

  task automatic cmp_model();
    int f = (q.size() > 4) ? 4 : q.size();
    check("a_match", a_match, m_match);
    check("a_cnt",   a_cnt,   m_cnt_a);
    check("a_sat",   a_sat,   m_sat_a);
    check("a_fill",  a_fill,  f);
    check("b_match", b_match, m_match);
    check("b_cnt",   b_cnt,   m_cnt_b);
    check("b_sat",   b_sat,   m_sat_b);
    check("b_fill",  b_fill,  f);
  endtask

  task automatic step(bit ld, bit [3:0] p, bit [3:0] m, bit ov,
                      bit v, bit b, bit clr);
    cfg_load = ld; cfg_pattern = p; cfg_mask = m; cfg_overlap = ov;
    in_valid = v; input_bit = b; clr_count = clr;
    @(posedge clk);
    model_edge(ld, p, m, ov, v, b, clr);
    #1;
    cmp_model();
  endtask

  task automatic bit_in(bit v, bit b);
    step(1'b0, 4'h0, 4'h0, 1'b0, v, b, 1'b0);
  endtask

  typedef struct {
    bit       ld;
    bit [3:0] pat;
    bit [3:0] msk;
    bit       ov;
    bit       v;
    bit       b;
    bit       e_match;
    int       e_cnt;
    int       e_fill;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit ld, bit [3:0] p, bit [3:0] m, bit ov,
                              bit v, bit b, bit em, int ec, int ef);
    vec_t r;
    r.ld = ld; r.pat = p; r.msk = m; r.ov = ov; r.v = v; r.b = b;
    r.e_match = em; r.e_cnt = ec; r.e_fill = ef;
    tbl.push_back(r);
  endfunction

  initial begin
    cfg_load = 0; cfg_pattern = 0; cfg_mask = 0; cfg_overlap = 0;
    in_valid = 0; input_bit = 0; clr_count = 0;
    reset = 1'b0;
    model_reset();

    // overlap: 1001 over 1,0,0,1,0,0,1
    add(1, 4'b1001, 4'b1111, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 0, 0, 0, 3);
    add(0, 0, 0, 0, 1, 1, 1, 1, 4);
    add(0, 0, 0, 0, 1, 0, 0, 1, 4);
    add(0, 0, 0, 0, 1, 0, 0, 1, 4);
    add(0, 0, 0, 0, 1, 1, 1, 2, 4);
    // non-overlap: same stream, count kept across load
    add(1, 4'b1001, 4'b1111, 0, 0, 0, 0, 2, 0);
    add(0, 0, 0, 0, 1, 1, 0, 2, 1);
    add(0, 0, 0, 0, 1, 0, 0, 2, 2);
    add(0, 0, 0, 0, 1, 0, 0, 2, 3);
    add(0, 0, 0, 0, 1, 1, 1, 3, 0);
    add(0, 0, 0, 0, 1, 0, 0, 3, 1);
    add(0, 0, 0, 0, 1, 0, 0, 3, 2);
    add(0, 0, 0, 0, 1, 1, 0, 3, 3);
    // valid gaps, bit 2 don't-care
    add(1, 4'b1001, 4'b1011, 1, 0, 0, 0, 3, 0);
    add(0, 0, 0, 0, 1, 1, 0, 3, 1);
    add(0, 0, 0, 0, 0, 1, 0, 3, 1);
    add(0, 0, 0, 0, 1, 1, 0, 3, 2);
    add(0, 0, 0, 0, 0, 0, 0, 3, 2);
    add(0, 0, 0, 0, 0, 1, 0, 3, 2);
    add(0, 0, 0, 0, 1, 0, 0, 3, 3);
    add(0, 0, 0, 0, 1, 1, 1, 4, 4);

    #3;
    check("rst_match", a_match, 0);
    check("rst_cnt",   a_cnt,   0);
    check("rst_sat",   a_sat,   0);
    check("rst_fill",  a_fill,  0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].pat, tbl[i].msk, tbl[i].ov,
           tbl[i].v, tbl[i].b, 1'b0);
      check($sformatf("tbl%0d_match", i), a_match, tbl[i].e_match);
      check($sformatf("tbl%0d_cnt", i),   a_cnt,   tbl[i].e_cnt);
      check($sformatf("tbl%0d_fill", i),  a_fill,  tbl[i].e_fill);
    end

    // saturation on the 2-bit counter, all-zero mask
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      bit_in(1'b1, 1'($urandom_range(1)));
      if (i >= 4) begin
        check($sformatf("sat_match%0d", i), b_match, 1);
        check($sformatf("sat_cnt%0d", i), b_cnt, (i - 3 > 3) ? 3 : i - 3);
        check($sformatf("sat_flag%0d", i), b_sat, (i >= 6) ? 1 : 0);
      end else begin
        check($sformatf("sat_match%0d", i), b_match, 0);
      end
    end
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_hit_match", b_match, 1);
    check("clr_hit_cnt",   b_cnt,   0);
    check("clr_hit_sat",   b_sat,   0);

    // reset mid-stream after a partial 1,0,0
    step(1'b1, 4'b1001, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    reset = 1'b0;
    model_reset();
    #2;
    check("mid_rst_match", a_match, 0);
    check("mid_rst_cnt",   a_cnt,   0);
    check("mid_rst_sat",   a_sat,   0);
    check("mid_rst_fill",  a_fill,  0);
    cmp_model();
    @(negedge clk);
    reset = 1'b1;
    bit_in(1'b1, 1'b1);
    check("post_rst_match", a_match, 0);
    check("post_rst_fill",  a_fill,  1);
    for (int i = 0; i < 4; i++) bit_in(1'b1, 1'b0);
    check("post_rst_zero_hit", a_match, 1);

    // bit presented with cfg_load is dropped
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
    check("load_match", a_match, 0);
    check("load_fill",  a_fill,  0);
    bit_in(1'b1, 1'b1);
    check("load_fill1", a_fill, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(24) == 0),
           4'($urandom), 4'($urandom | ($urandom_range(3) == 0 ? 0 : 32'hC)),
           1'($urandom_range(1)),
           ($urandom_range(3) != 0),
           1'($urandom_range(1)),
           ($urandom_range(40) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed-pattern Mealy sequence detector.
- The pattern length, pattern value, compare mask and overlap mode are all configurable.
- Adds a valid qualifier, a saturating match counter and a fill-level status output.
- Sits on serial input streams in the lab datapath; match pulses feed downstream counters and interrupt logic.

Parameters:
- PAT_LEN, 4, pattern length in bits (legal range 2..32).
- CNT_W, 8, width of the saturating match counter (legal range 1..32).
- FILL_W, $clog2(PAT_LEN+1), width of the fill-level output (derived; do not override).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cfg_load  input  1  latch cfg_pattern, cfg_mask and cfg_overlap; restarts detection.
- cfg_pattern  input  PAT_LEN  target pattern; bit PAT_LEN-1 is the first bit received.
- cfg_mask  input  PAT_LEN  per-bit compare enable; 1 = compare, 0 = don't-care.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  input  1  input_bit is sampled only when high.
- input_bit  input  1  serial data bit.
- clr_count  input  1  synchronous clear of match_count and sat.
- match  output  1  registered one-cycle pulse on pattern completion.
- match_count  output  CNT_W  saturating count of matches.
- sat  output  1  sticky flag, high once match_count has reached all-ones.
- fill  output  FILL_W  valid bits accumulated since restart, capped at PAT_LEN.

Behaviour:
- Reset (reset low, asynchronous):
  - Outputs: match=0, match_count=0, sat=0, fill=0.
  - Internal registers: history=0, pattern=0, mask=all-ones, overlap=1.
- History shift on each accepted bit (in_valid=1, cfg_load=0): history <= {history[PAT_LEN-2:0], input_bit}.
- Hit condition, evaluated combinationally on the accepted bit:
  - ((({history[PAT_LEN-2:0], input_bit}) XOR pattern) AND mask) == 0, AND
  - fill >= PAT_LEN-1.
  - The fill condition prevents false hits before PAT_LEN bits have been accepted.
- Latency: match goes high on the clock edge that accepts the completing bit, so it is visible during the cycle after that bit is presented. It is high for exactly one cycle per hit.
- Fill update:
  - No hit: fill <= min(fill+1, PAT_LEN).
  - Hit, overlap=1: fill stays at PAT_LEN.
  - Hit, overlap=0: fill <= 0 and history is cleared, so the bits of a match are never reused.
- in_valid=0: no shift, no fill change, match=0.
- cfg_load=1:
  - Latches pattern, mask and overlap.
  - Clears fill and history; match=0.
  - Any bit presented in the same cycle is discarded.
  - match_count and sat are kept.
- Counter: on a hit, match_count increments unless already all-ones. sat goes high once match_count equals all-ones and stays high until clr_count or reset.
- clr_count=1: match_count <= 0 and sat <= 0. If a hit occurs in the same cycle, the clear wins: count=0, sat=0, but match still pulses.
- An all-zero mask matches every accepted bit once fill >= PAT_LEN-1.
- Reset asserted mid-stream aborts any partial match immediately. No match pulse is issued until PAT_LEN new valid bits have been accepted after reset release.

Test Plan:
- Overlap detection: PAT_LEN=4, load pattern 1001, mask 1111, overlap=1, stream 1,0,0,1,0,0,1 with in_valid=1 -> match pulses after bits 4 and 7; match_count=2; fill=4 at end.
- Non-overlap detection: same stream with overlap=0 -> single match after bit 4; match_count=1; fill=3 at end.
- Valid gaps and don't-care mask: pattern 1001, mask 1011, stream 1,(gap),1,(gap,gap),0,1 -> match after the 4th valid bit (bit 2 is don't-care); no match pulse in any gap cycle.
- Counter saturation: CNT_W=2, all-zero mask, 7 valid bits -> count sequence 1,2,3,3; sat high from the 3rd match onward. Then clr_count together with a hit -> count=0, sat=0, match=1.
- Reset and reconfiguration mid-stream:
  - Drive reset low after 1,0,0 -> all outputs 0; then 1 -> no match.
  - Separately, cfg_load with in_valid=1 -> that bit is ignored; fill=0 next cycle.
